// File: rtl/lif_scheduler.sv
// Round-robin front end that time-shares one LIF neuron unit between N PE columns.
// One job in flight at a time; result returned tagged with the requester id.
module lif_scheduler #(
  parameter int             N       = 4,
  parameter int             T       = 4,
  parameter int             Q       = 10,
  parameter logic [Q-1:0]   THR_RST = 10'd512,
  parameter int             TMO     = T + 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*T*Q-1:0]       req_data,
  output logic [N-1:0]           req_ready,
  input  logic                   cfg_thr_we,
  input  logic [Q-1:0]           cfg_thr,
  output logic                   lif_start,
  output logic                   lif_result_val,
  output logic [T*Q-1:0]         lif_input_data,
  output logic [Q-1:0]           lif_threshold,
  input  logic [T-1:0]           lif_spike_out,
  input  logic                   lif_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_id,
  output logic [T-1:0]           out_spikes,
  output logic                   out_err,
  output logic [15:0]            jobs_done
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  typedef struct packed {
    logic [T*Q-1:0] data;
    logic [Q-1:0]   thr;
    logic [IW-1:0]  id;
  } job_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [Q-1:0]    thr_q, thr_d;
  job_t            job_q, job_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [T-1:0]    spk_q, spk_d;
  logic            err_q, err_d;
  logic [15:0]     jobs_q, jobs_d;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [N-1:0]    gnt_oh;
  logic            start;
  logic            ov;

  // First pending requester strictly after the last one served, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!gnt_found && req_valid[(int'(rr_q) + k) % N]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(rr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    thr_d   = cfg_thr_we ? cfg_thr : thr_q;
    job_d   = job_q;
    tmo_d   = tmo_q;
    spk_d   = spk_q;
    err_d   = err_q;
    jobs_d  = jobs_q;
    gnt_oh  = '0;
    start   = 1'b0;
    ov      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          gnt_oh[gnt_idx] = 1'b1;
          // thr_q, not thr_d: a write in the grant cycle applies to later jobs only
          job_d.data = req_data[int'(gnt_idx)*T*Q +: T*Q];
          job_d.thr  = thr_q;
          job_d.id   = gnt_idx;
          rr_d       = gnt_idx;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        start   = 1'b1;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + CW'(1);
        if (lif_done) begin
          spk_d   = lif_spike_out;
          err_d   = 1'b0;
          state_d = OUT;
        end else if (tmo_q == CW'(TMO - 1)) begin
          spk_d   = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        ov = 1'b1;
        if (out_ready) begin
          jobs_d  = jobs_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= IW'(N - 1);
      thr_q   <= THR_RST;
      job_q   <= '0;
      tmo_q   <= '0;
      spk_q   <= '0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      thr_q   <= thr_d;
      job_q   <= job_d;
      tmo_q   <= tmo_d;
      spk_q   <= spk_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
    end
  end

  // Grant is combinational from IDLE; masking with rst_n keeps it quiet while held in reset.
  assign req_ready      = gnt_oh & {N{rst_n}};
  assign lif_start      = start;
  assign lif_result_val = start;
  assign lif_input_data = job_q.data;
  assign lif_threshold  = job_q.thr;
  assign out_valid      = ov;
  assign out_id         = job_q.id;
  assign out_spikes     = spk_q;
  assign out_err        = err_q;
  assign jobs_done      = jobs_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler with a behavioural LIF stand-in driving lif_done/spikes.
module tb_lif_scheduler;
  localparam int N = 4, T = 4, Q = 10, TMO = T + 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N*T*Q-1:0] req_data;
  logic [N-1:0]     req_ready;
  logic             cfg_thr_we;
  logic [Q-1:0]     cfg_thr;
  logic             lif_start, lif_result_val;
  logic [T*Q-1:0]   lif_input_data;
  logic [Q-1:0]     lif_threshold;
  logic [T-1:0]     lif_spike_out;
  logic             lif_done;
  logic             out_valid, out_ready;
  logic [1:0]       out_id;
  logic [T-1:0]     out_spikes;
  logic             out_err;
  logic [15:0]      jobs_done;

  int total = 0, bad = 0, cyc = 0;
  int stub_mode = 0;   // 0: normal LIF, 1: never raises lif_done

  lif_scheduler #(.N(N), .T(T), .Q(Q), .THR_RST(10'd512), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_thr_we(cfg_thr_we), .cfg_thr(cfg_thr),
    .lif_start(lif_start), .lif_result_val(lif_result_val),
    .lif_input_data(lif_input_data), .lif_threshold(lif_threshold),
    .lif_spike_out(lif_spike_out), .lif_done(lif_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_spikes(out_spikes), .out_err(out_err), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wait_grant(input int max, output int n);
    n = 0; #1;
    while (req_ready == '0 && n < max) begin tick(); n++; end
  endtask

  task automatic wait_out(input int max, output int n);
    n = 0; #1;
    while (!out_valid && n < max) begin tick(); n++; end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [T*Q-1:0] vec(input int v);
    logic [Q-1:0] e = v[Q-1:0];
    return {T{e}};
  endfunction

  // Integrate-and-fire, reset to zero on spike; spike for timestep t lands in bit t.
  function automatic logic [T-1:0] lif_calc(input logic [T*Q-1:0] d, input logic [Q-1:0] th);
    int pot = 0;
    logic [T-1:0] s = '0;
    for (int t = 0; t < T; t++) begin
      pot += int'(d[t*Q +: Q]);
      if (pot >= int'(th)) begin s[t] = 1'b1; pot = 0; end
    end
    return s;
  endfunction

  // LIF stand-in: done pulse in cycle T+3 relative to the grant, i.e. T+2 cycles after lif_start.
  initial begin : lif_stub
    logic [T*Q-1:0] d0;
    logic [Q-1:0]   t0;
    lif_done = 1'b0;
    lif_spike_out = '0;
    forever begin
      @(posedge clk); #1;
      if (lif_start && stub_mode == 0) begin
        d0 = lif_input_data;
        t0 = lif_threshold;
        repeat (T + 2) @(posedge clk);
        #1;
        lif_spike_out = lif_calc(d0, t0);
        lif_done = 1'b1;
        if (rst_n) begin
          chk("hold_data", lif_input_data, d0);
          chk("hold_thr", lif_threshold, t0);
        end
        @(posedge clk); #1;
        lif_done = 1'b0;
        lif_spike_out = '0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int gid[5];
    int gcyc[5];
    req_valid  = '1;
    req_data   = {vec(45), vec(40), vec(43), vec(41)};
    cfg_thr_we = 1'b0;
    cfg_thr    = '0;
    out_ready  = 1'b1;

    // Reset: everything quiet even with all requests pending
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_start", {lif_start, lif_result_val}, 2'b00);
    chk("rst_lif_data", lif_input_data, '0);
    chk("rst_lif_thr", lif_threshold, '0);
    chk("rst_out", {out_valid, out_id, out_spikes, out_err}, '0);
    chk("rst_jobs", jobs_done, 16'd0);

    // Round robin from reset: 0,1,2,3,0 spaced T+5 apart
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, n);
      gid[k]  = oh2i(req_ready);
      gcyc[k] = cyc;
      chk("rr_order", gid[k], k % N);
      if (k > 0) chk("rr_spacing", gcyc[k] - gcyc[k-1], T + 5);
      tick();
    end
    req_valid = '0;
    wait_out(20, n);
    chk("rr_last_out", {out_id, out_spikes, out_err}, {2'd0, 4'b0000, 1'b0});
    tick();
    chk("rr_jobs", jobs_done, 16'd5);

    // Single job: requester 2, data all 40, thr 100
    cfg_thr_we = 1'b1; cfg_thr = 10'd100;
    tick();
    cfg_thr_we = 1'b0;
    req_valid = 4'b0100;
    wait_grant(5, n);
    chk("sj_grant", req_ready, 4'b0100);
    chk("sj_grant_wait", n, 0);
    tick();
    req_valid = '0;
    chk("sj_start", {lif_start, lif_result_val}, 2'b11);
    chk("sj_lif_data", lif_input_data, vec(40));
    chk("sj_lif_thr", lif_threshold, 10'd100);
    tick();
    chk("sj_start_pulse", lif_start, 1'b0);
    wait_out(20, n);
    chk("sj_latency", n + 2, T + 4);
    chk("sj_result", {out_id, out_spikes, out_err}, {2'd2, 4'b0100, 1'b0});
    tick();
    chk("sj_after", {out_valid, jobs_done}, {1'b0, 16'd6});

    // Backpressure: requester 3, others pending while result is held
    out_ready = 1'b0;
    req_valid = 4'b1000;
    wait_grant(5, n);
    chk("bp_grant", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0111;
    wait_out(20, n);
    chk("bp_latency", n + 1, T + 4);
    repeat (20) begin
      tick();
      chk("bp_hold", {out_valid, out_id, out_spikes, out_err, req_ready},
          {1'b1, 2'd3, 4'b0100, 1'b0, 4'b0000});
    end
    out_ready = 1'b1;
    tick();
    // Grant cycle right after the handshake, with a threshold write in the same cycle
    cfg_thr_we = 1'b1; cfg_thr = 10'd30;
    #1;
    chk("bp_next_grant", req_ready, 4'b0001);
    chk("bp_jobs", jobs_done, 16'd7);
    tick();
    cfg_thr_we = 1'b0;
    req_valid = 4'b0010;
    chk("thr_old_used", lif_threshold, 10'd100);
    chk("thr_old_data", lif_input_data, vec(41));
    wait_out(20, n);
    chk("thr_old_result", {out_id, out_spikes, out_err}, {2'd0, 4'b0100, 1'b0});
    tick();
    wait_grant(5, n);
    chk("thr_new_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("thr_new_used", lif_threshold, 10'd30);
    wait_out(20, n);
    chk("thr_new_result", {out_id, out_spikes, out_err}, {2'd1, 4'b1111, 1'b0});
    tick();
    chk("thr_jobs", jobs_done, 16'd9);

    // Timeout: LIF never answers
    stub_mode = 1;
    req_valid = 4'b1000;
    wait_grant(5, n);
    chk("to_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    wait_out(40, n);
    chk("to_latency", n + 1, TMO + 2);
    chk("to_result", {out_id, out_spikes, out_err}, {2'd3, 4'b0000, 1'b1});
    tick();
    stub_mode = 0;
    chk("to_jobs", jobs_done, 16'd10);
    req_valid = 4'b0001;
    wait_grant(5, n);
    tick();
    req_valid = '0;
    wait_out(20, n);
    chk("to_recover", {out_id, out_spikes, out_err}, {2'd0, 4'b1111, 1'b0});
    tick();
    chk("to_rec_jobs", jobs_done, 16'd11);

    // Reset in the middle of WAIT
    req_valid = 4'b0100;
    wait_grant(5, n);
    chk("mr_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("mr_outputs", {req_ready, lif_start, lif_result_val, lif_input_data, lif_threshold,
                       out_valid, out_id, out_spikes, out_err, jobs_done}, '0);
    repeat (6) begin
      tick();
      chk("mr_no_out", out_valid, 1'b0);
    end
    rst_n = 1'b1;
    wait_grant(3, n);
    chk("mr_next_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("mr_thr_reset", lif_threshold, 10'd512);
    wait_out(20, n);
    chk("mr_result", {out_id, out_spikes, out_err}, {2'd0, 4'b0000, 1'b0});
    tick();
    chk("mr_jobs", jobs_done, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

Round-robin scheduler that shares one LIF neuron unit (T timesteps, Q-bit quantization) between N requesting PE columns. Accepts one T×Q input vector per request and latches a threshold for each job. Sequences the LIF start/result_val handshake, holds the LIF input stable for the whole computation and captures the T-bit spike result when the LIF signals done. Returns the result, tagged with the requester ID, through a valid/ready output port.

## Interface
- N, 4, number of requesters (≥2)
- T, 4, LIF timesteps; must match the LIF instance
- Q, 10, bits per timestep input / threshold
- THR_RST, 10'd512, threshold register reset value
- TMO, T+8, cycles to wait for lif_done before timeout
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N  per-requester job pending
- req_data  in  N*T*Q  requester i data at [i*T*Q +: T*Q]
- req_ready  out  N  one-hot, one-cycle accept pulse
- cfg_thr_we  in  1  write threshold register
- cfg_thr  in  Q  threshold write data
- lif_start  out  1  LIF start
- lif_result_val  out  1  LIF input-valid qualifier
- lif_input_data  out  T*Q  held job data to LIF
- lif_threshold  out  Q  held job threshold to LIF
- lif_spike_out  in  T  LIF spike vector
- lif_done  in  1  LIF done pulse
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_id  out  $clog2(N)  requester index of result
- out_spikes  out  T  captured spikes
- out_err  out  1  result produced by timeout (spikes forced 0)
- jobs_done  out  16  completed-job counter, wraps at 0xFFFF→0

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: if any req_valid, grant the first set bit searching from (rr_ptr+1) mod N upward with wrap. Pulse req_ready[g]. Latch req_data slice, thr_reg and g into hold registers. Set rr_ptr←g. Go to ISSUE. With no requests, stay in IDLE.
- ISSUE: lif_start=lif_result_val=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: lif_start=lif_result_val=0. Increment the timeout counter each cycle.
  - On lif_done: capture lif_spike_out into out_spikes, out_err←0, go to OUT.
  - If the counter reaches TMO with no lif_done: out_spikes←0, out_err←1, go to OUT.
- OUT: out_valid=1. Hold out_id, out_spikes and out_err stable until out_valid&out_ready. On that handshake: jobs_done+1 (errored jobs also count), go to IDLE.
- lif_input_data and lif_threshold come from the hold registers and stay constant from ISSUE through OUT. The LIF samples its input combinationally every CALC cycle, so these must not change during a job.
- cfg_thr_we updates thr_reg in any state. The new value affects only jobs granted afterwards. A write in the same cycle as a grant: the grant latches the old value.
- Reset values: rr_ptr=N-1 (requester 0 wins first), thr_reg=THR_RST, hold registers 0. All outputs are 0: req_ready, lif_start, lif_result_val, lif_input_data, lif_threshold=0 until the first grant, out_valid, out_id, out_spikes, out_err, jobs_done. State=IDLE.
- Reset mid-job aborts the job with no output. The LIF shares rst_n and resets with this block.

## Timing
- Grant at cycle 0 (req_ready high). lif_start at cycle 1. LIF is in CALC for cycles 2..T+2 (T+1 cycles) and DONE at cycle T+3. out_valid rises at cycle T+4.
- Minimum grant-to-grant spacing is T+5 cycles with out_ready tied high. The next grant can occur at the earliest in the cycle after the output handshake.
- A requester must hold req_valid and req_data until it sees req_ready. Deasserting before grant withdraws the request.
- Only one job is in flight at a time. req_ready is never asserted outside IDLE.
- lif_done outside WAIT is ignored.

## Test plan
- Single job: N=4, req 2 data {40,40,40,40} (t0 in low Q bits), thr=100 → req_ready=4'b0100 at cycle 0, lif_start at cycle 1, out_valid at cycle 8 (T=4), out_id=2, out_spikes=4'b0100 (potential 40,80,120 fires at t2, then 40), jobs_done=1.
- Round-robin fairness: all four req_valid held high, out_ready=1 → grant order 0,1,2,3,0, grants spaced exactly 9 cycles apart.
- Backpressure: out_ready=0 for 20 cycles after out_valid → outputs stable, no new req_ready. out_ready=1 → handshake, next grant one cycle later.
- Threshold change: cfg_thr_we with thr=30 in the grant cycle → that job uses the old threshold. The next job uses 30; data all 40 gives spikes 4'b1111.
- Timeout: LIF stub never raises lif_done → out_valid at cycle TMO+2 with out_err=1, out_spikes=0. A subsequent normal job returns out_err=0.
- Reset mid-WAIT: rst_n low at cycle 4 → all outputs 0 immediately, no out_valid follows, next grant goes to requester 0.
